// File: rtl/fifo_wr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter_if                                            |
// | Purpose  : Bundles the requester handshake and FIFO write-port signals   |
// |            seen by fifo_wr_arbiter.                                      |
// | Signals  : reqValid/reqData/reqLast/reqReady - per-requester beat bus,   |
// |            requester i owns reqData[i*W +: W].                           |
// |            fifoFull/fifoWrEn/fifoDin - FIFO write port.                  |
// |            grantId/busy - arbitration status.                            |
// | Modports : master - the arbiter side; slave - requesters plus FIFO.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int WR_DATA_WIDTH_MUL = 1
);
  localparam int c_W    = WR_DATA_WIDTH_MUL * DATA_WIDTH;
  localparam int c_ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]     reqValid;
  logic [NUM_REQ*c_W-1:0] reqData;
  logic [NUM_REQ-1:0]     reqLast;
  logic [NUM_REQ-1:0]     reqReady;
  logic                   fifoFull;
  logic                   fifoWrEn;
  logic [c_W-1:0]         fifoDin;
  logic [c_ID_W-1:0]      grantId;
  logic                   busy;

  modport master (
    input  reqValid, reqData, reqLast, fifoFull,
    output reqReady, fifoWrEn, fifoDin, grantId, busy
  );

  modport slave (
    output reqValid, reqData, reqLast, fifoFull,
    input  reqReady, fifoWrEn, fifoDin, grantId, busy
  );
endinterface
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_wr_arbiter                                               |
// | Purpose  : Write-side scheduler for the dual-clock FIFO. Shares the one  |
// |            FIFO write port among NUM_REQ requesters with round-robin     |
// |            arbitration, bursts capped at MAX_BURST beats and release of  |
// |            an idle grant after IDLE_TIMEOUT cycles.                      |
// | Ports    : wrClk - write-domain clock (FIFO wrClk)                       |
// |            rst   - synchronous active-high reset                         |
// |            bus   - fifo_wr_arbiter_if.master (requesters + FIFO port)    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_wr_arbiter #(
  parameter int NUM_REQ           = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int WR_DATA_WIDTH_MUL = 1,
  parameter int MAX_BURST         = 8,
  parameter int IDLE_TIMEOUT      = 4
) (
  input  logic               wrClk,
  input  logic               rst,
  fifo_wr_arbiter_if.master  bus
);
  localparam int c_W      = WR_DATA_WIDTH_MUL * DATA_WIDTH;
  localparam int c_ID_W   = $clog2(NUM_REQ);
  localparam int c_BEAT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam int c_IDLE_W = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;

  localparam logic [c_ID_W-1:0]   c_ID_MAX    = c_ID_W'(NUM_REQ - 1);
  localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(MAX_BURST - 1);
  localparam logic [c_IDLE_W-1:0] c_IDLE_LAST = c_IDLE_W'(IDLE_TIMEOUT - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_stateNxt;
  logic [c_ID_W-1:0]   r_grantId;
  logic [c_ID_W-1:0]   r_lastGrant;
  logic [c_BEAT_W-1:0] r_beatCnt;
  logic [c_IDLE_W-1:0] r_idleCnt;

  logic [c_ID_W-1:0]   w_cand;
  logic [c_ID_W-1:0]   w_sel;
  logic                w_found;
  logic                w_active;
  logic                w_gValid;
  logic                w_gLast;
  logic                w_xfer;
  logic                w_endBurst;
  logic                w_idle;
  logic                w_timeout;

  // Round-robin search starting just after the last granted requester.
  // The increment wraps explicitly so non-power-of-two NUM_REQ is handled.
  always_comb begin
    w_found = 1'b0;
    w_sel   = r_lastGrant;
    w_cand  = r_lastGrant;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = (w_cand == c_ID_MAX) ? '0 : w_cand + c_ID_W'(1);
      if (!w_found && bus.reqValid[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  // Reset gates the write path so no beat is accepted in a reset cycle.
  assign w_active   = (r_state == BURST) && !rst;
  assign w_gValid   = bus.reqValid[r_grantId];
  assign w_gLast    = bus.reqLast[r_grantId];
  assign w_xfer     = w_active && !bus.fifoFull && w_gValid;
  assign w_endBurst = w_xfer && (w_gLast || (r_beatCnt == c_BEAT_LAST));
  // Only a truly idle requester counts toward the timeout; back-pressure
  // (fifoFull) freezes the counter instead.
  assign w_idle     = w_active && !bus.fifoFull && !w_gValid;
  assign w_timeout  = w_idle && (r_idleCnt == c_IDLE_LAST);

  always_comb begin
    bus.reqReady = '0;
    if (w_active && !bus.fifoFull) begin
      bus.reqReady[r_grantId] = 1'b1;
    end
  end

  assign bus.fifoWrEn = w_xfer;
  assign bus.fifoDin  = w_xfer ? bus.reqData[int'(r_grantId) * c_W +: c_W] : '0;
  assign bus.grantId  = r_grantId;
  assign bus.busy     = (r_state == BURST);

  always_comb begin
    w_stateNxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_stateNxt = BURST;
      BURST:   if (w_endBurst || w_timeout) w_stateNxt = IDLE;
      default: w_stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge wrClk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNxt;
    end
  end

  always_ff @(posedge wrClk) begin
    if (rst) begin
      r_grantId   <= '0;
      r_lastGrant <= c_ID_MAX;
      r_beatCnt   <= '0;
      r_idleCnt   <= '0;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_grantId <= w_sel;
        r_beatCnt <= '0;
        r_idleCnt <= '0;
      end
    end else begin
      if (w_xfer) begin
        r_beatCnt <= r_beatCnt + c_BEAT_W'(1);
        r_idleCnt <= '0;
      end else if (w_idle && !w_timeout) begin
        r_idleCnt <= r_idleCnt + c_IDLE_W'(1);
      end
      if (w_endBurst || w_timeout) begin
        r_lastGrant <= r_grantId;
      end
    end
  end

endmodule
`default_nettype wire
